// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BCD_W = 4;

  // Split a whole-seconds load value into its BCD tens/ones digits.
  function automatic logic [BCD_W-1:0] load_tens(input int unsigned sec);
    return BCD_W'(sec / 10);
  endfunction

  function automatic logic [BCD_W-1:0] load_ones(input int unsigned sec);
    return BCD_W'(sec % 10);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_digit.sv
// One BCD digit that counts down 9..0 with wrap; borrow flags a 0 -> 9 step.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             borrow
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= load_val;
    end else if (dec) begin
      q <= (q == '0) ? BCD_W'(9) : q - BCD_W'(1);
    end
  end

  assign borrow = dec && (q == '0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Game countdown timer: gates the 100 ms tick generator, counts SS.t down in BCD,
// and reports running / low-time warning / timeout to the game FSM.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned LOAD_SEC = 30,
  parameter int unsigned WARN_SEC = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             ms100,
  output logic             tick_en,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] tenths,
  output logic             running,
  output logic             warn,
  output logic             timeout
);

  if (LOAD_SEC < 1 || LOAD_SEC > 99) begin : g_bad_load
    $error("countdown_timer_ctrl: LOAD_SEC must be 1..99");
  end
  if (WARN_SEC > LOAD_SEC) begin : g_bad_warn
    $error("countdown_timer_ctrl: WARN_SEC must be 0..LOAD_SEC");
  end

  localparam logic [BCD_W-1:0] LOAD_TENS = load_tens(LOAD_SEC);
  localparam logic [BCD_W-1:0] LOAD_ONES = load_ones(LOAD_SEC);

  state_t     state, state_n;
  logic       load, dec, timeout_n, warn_n;
  logic       tenths_borrow, ones_borrow, tens_borrow_unused;
  logic       at_last_tenth;
  logic [6:0] secs_cur, secs_n;

  bcd_down_digit u_tenths (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val ('0),
    .dec      (dec),
    .q        (tenths),
    .borrow   (tenths_borrow)
  );

  bcd_down_digit u_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (LOAD_ONES),
    .dec      (tenths_borrow),
    .q        (sec_ones),
    .borrow   (ones_borrow)
  );

  // Tens never borrows: the terminal 00.0 is caught before any underflow.
  bcd_down_digit u_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (LOAD_TENS),
    .dec      (ones_borrow),
    .q        (sec_tens),
    .borrow   (tens_borrow_unused)
  );

  assign at_last_tenth = (sec_tens == '0) && (sec_ones == '0) && (tenths == BCD_W'(1));

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    dec       = 1'b0;
    timeout_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      load    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause) state_n = RUN;
        end
        RUN: begin
          if (ms100) begin
            dec = 1'b1;
            // Reaching 00.0 ends the game even if pause arrives on the same tick.
            if (at_last_tenth) begin
              state_n   = DONE;
              timeout_n = 1'b1;
            end else if (pause) begin
              state_n = PAUSE;
            end
          end else if (pause) begin
            state_n = PAUSE;
          end
        end
        PAUSE: begin
          if (pause || start) state_n = RUN;
        end
        DONE: begin
          if (start && !pause) begin
            state_n = RUN;
            load    = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Warn looks at the seconds value that will be visible after this edge.
  always_comb begin
    secs_cur = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
    if (load)               secs_n = 7'(LOAD_SEC);
    else if (tenths_borrow) secs_n = secs_cur - 7'd1;
    else                    secs_n = secs_cur;
    warn_n = ((state_n == RUN) || (state_n == PAUSE)) && (secs_n < 7'(WARN_SEC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tick_en <= 1'b0;
      running <= 1'b0;
      warn    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      tick_en <= (state_n == RUN);
      running <= (state_n == RUN);
      warn    <= warn_n;
      timeout <= timeout_n;
    end
  end

endmodule
